ntt_coeff_loader: RTL and testbench
===================================

// Module: ntt_coeff_loader
// PURPOSE
//  Upstream stage of the NTT/INTT BRAM core. Accepts a 256-coefficient polynomial over a
//  valid/ready stream and reduces each beat mod Q. Writes beat i to coefficient BRAM
//  address i, then pulses the core's start input with the latched mode.
//  Waits for the core's done, then reports completion. Owns the BRAM write port only
//  while loading.
// PARAMETERS
//  N   256   coefficients per polynomial (power of 2)
//  AW  8     BRAM address width, log2(N)
//  DW  16    coefficient / BRAM data width
//  Q   3329  modulus; Barrett constant M = floor(2^26/Q) (20158 for Q=3329), shift 26
// PORTS
//  clk        in   1   rising-edge clock, single clock domain
//  rst        in   1   reset, synchronous, active-low (0 = reset)
//  go         in   1   1-cycle request to start a load; sampled only in IDLE
//  mode       in   1   0 = NTT, 1 = INTT; latched when go is accepted
//  s_valid    in   1   input coefficient valid
//  s_ready    out  1   loader can accept a beat
//  s_data     in   DW  unsigned coefficient, any value 0..2^DW-1
//  s_last     in   1   marks final beat (must be beat N-1)
//  bram_we    out  1   BRAM write enable
//  bram_addr  out  AW  BRAM write address
//  bram_din   out  DW  BRAM write data, always < Q
//  ntt_start  out  1   1-cycle start pulse to core
//  ntt_mode   out  1   mode to core, held from go until next go
//  ntt_done   in   1   core done; first high cycle in WAIT is taken as completion
//  busy       out  1   state != IDLE
//  done       out  1   1-cycle pulse when core finished
//  err_len    out  1   sticky length error; cleared on accepted go or reset
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state=IDLE; every output 0, including ntt_mode; counter=0.
//    Reset mid-operation aborts immediately. No further BRAM write or ntt_start occurs.
//  FSM: IDLE -go-> LOAD -> FLUSH -> KICK -> WAIT -ntt_done-> DONE -> IDLE.
//  IDLE: s_ready=0. On go=1: latch mode into ntt_mode, clear err_len, cnt=0, go to LOAD.
//    go is ignored in all other states.
//  LOAD: s_ready=1. A beat is accepted when s_valid&s_ready.
//    Reduction: t=(x*M)>>26; r=x-t*Q; if r>=Q then r-=Q. Result is 0..Q-1 for any x.
//    Accepted beat k is registered and written the next cycle: bram_we=1, bram_addr=k,
//    bram_din=r. One write per beat; no write in cycles without an accepted beat.
//    Accept with cnt<N-1 and s_last=1: early end. err_len=1, the beat is still written,
//      go to IDLE, no ntt_start.
//    Accept with cnt==N-1: go to FLUSH regardless of s_last. If s_last=0, set err_len=1
//      and continue normally.
//    cnt wraps never: cnt is compared against N-1 before increment.
//  FLUSH: s_ready=0. The final write (addr N-1) is issued in this cycle.
//  KICK: ntt_start=1 for exactly this cycle. No BRAM write from loader.
//  WAIT: s_ready=0. ntt_done is ignored in KICK and sampled from the cycle after.
//    The first cycle with ntt_done=1 moves to DONE.
//  DONE: done=1 for one cycle, then IDLE. A go in this cycle is ignored; it is accepted
//    only from IDLE.
//  Latency: last accepted beat at cycle T -> write at T+1, ntt_start at T+2.
//    Earliest done is at the cycle after ntt_done is first seen.
//  Back-pressure/gaps: s_valid may drop at any time in LOAD. The loader waits, and
//    addresses stay contiguous.
// TESTING
//  1 Reset: hold rst=0 3 cycles with go=1,s_valid=1 -> all outputs 0, no write, busy=0.
//  2 Ramp: go,mode=1; send s_data=k for k=0..255, s_last on 255 ->
//    BRAM[k]=k; ntt_start 2 cycles after beat 255; ntt_mode=1.
//    Then ntt_done=1 for 1 cycle -> done pulse 1 cycle later.
//  3 Reduction: beats 3329, 3328, 65535, 6658 -> BRAM values 0, 3328, 2284, 0.
//  4 Early last: s_last on beat 10 -> writes at addr 0..10, err_len=1, state IDLE,
//    ntt_start never asserted. A new go clears err_len.
//  5 Missing last + gaps: random s_valid gaps, no s_last -> 256 contiguous writes,
//    err_len=1, ntt_start still pulses once.
//  6 Reset mid-load at beat 100, then a full load -> second run complete and correct.
//    No start from the aborted run.

Source files
------------

// File: rtl/ntt_coeff_loader_if.sv
// Coefficient stream into the NTT loader: valid/ready with a last-beat marker.
interface ntt_coeff_loader_if #(
    parameter int DW = 16
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/ntt_coeff_loader.sv
// Loads one polynomial into the NTT core's coefficient BRAM, reducing each beat mod Q,
// then kicks the core and reports when it finishes.
module ntt_coeff_loader #(
    parameter int N  = 256,
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int Q  = 3329,
    parameter int BM = 20158
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                mode,
    ntt_coeff_loader_if.slave   s,
    output logic                bram_we,
    output logic [AW-1:0]       bram_addr,
    output logic [DW-1:0]       bram_din,
    output logic                ntt_start,
    output logic                ntt_mode,
    input  logic                ntt_done,
    output logic                busy,
    output logic                done,
    output logic                err_len
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_KICK  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int          PW       = 2 * DW;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    // Barrett with shift 26 leaves at most one extra Q for any DW-bit input.
    function automatic logic [DW-1:0] barrett_reduce(input logic [DW-1:0] x);
        logic [PW-1:0] prod;
        logic [PW-1:0] tq;
        logic [PW-1:0] r;
        prod = {{DW{1'b0}}, x} * PW'(BM);
        tq   = (prod >> 26) * PW'(Q);
        r    = {{DW{1'b0}}, x} - tq;
        r    = (r >= PW'(Q)) ? (r - PW'(Q)) : r;
        return DW'(r);
    endfunction

    logic [2:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;
    logic          r_start;
    logic          r_mode;
    logic          r_done;
    logic          r_err;

    logic w_ready;
    logic w_accept;
    logic w_at_last;

    // Beat acceptance decode from the registered state.
    always_comb begin
        w_ready   = (r_state == ST_LOAD);
        w_accept  = s.s_valid & w_ready;
        w_at_last = (r_cnt == LAST_IDX);
    end

    // Sequencer: load, flush final write, kick core, wait for it, report.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {AW{1'b0}};
            r_we    <= 1'b0;
            r_addr  <= {AW{1'b0}};
            r_din   <= {DW{1'b0}};
            r_start <= 1'b0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_mode  <= mode;
                        r_err   <= 1'b0;
                        r_cnt   <= {AW{1'b0}};
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_we   <= 1'b1;
                        r_addr <= r_cnt;
                        r_din  <= barrett_reduce(s.s_data);
                        // Counter is checked before increment so it never wraps.
                        if (w_at_last) begin
                            r_state <= ST_FLUSH;
                            if (!s.s_last) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                            if (s.s_last) begin
                                r_err   <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    r_start <= 1'b1;
                    r_state <= ST_KICK;
                end
                ST_KICK: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ntt_done) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.s_ready = w_ready;
    assign bram_we   = r_we;
    assign bram_addr = r_addr;
    assign bram_din  = r_din;
    assign ntt_start = r_start;
    assign ntt_mode  = r_mode;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err_len   = r_err;

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Scoreboarded bench for ntt_coeff_loader: every accepted beat queues its expected
// BRAM write, and a negedge monitor pops and compares each write the loader issues.
module tb_ntt_coeff_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic        mode = 1'b0;
    logic        ntt_done = 1'b0;
    logic        bram_we;
    logic [7:0]  bram_addr;
    logic [15:0] bram_din;
    logic        ntt_start;
    logic        ntt_mode;
    logic        busy;
    logic        done;
    logic        err_len;

    ntt_coeff_loader_if #(.DW(16)) sif ();

    ntt_coeff_loader dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .mode      (mode),
        .s         (sif),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .ntt_start (ntt_start),
        .ntt_mode  (ntt_mode),
        .ntt_done  (ntt_done),
        .busy      (busy),
        .done      (done),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [15:0] mem [0:255];
    logic [15:0] exp_mem [0:255];
    int          writes = 0;
    int          starts = 0;
    int          dones = 0;
    int          next_addr = 0;

    function automatic int ref_mod(input int x);
        return x % 3329;
    endfunction

    // Write/start/done monitor and scoreboard pop.
    always @(negedge clk) begin
        if (ntt_start === 1'b1) starts++;
        if (done === 1'b1) dones++;
        if (bram_we === 1'b1) begin
            writes++;
            mem[bram_addr] = bram_din;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d din=%0d, expected no write", bram_addr, bram_din);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bram_addr, bram_din} !== mon_e) begin
                    failures++;
                    $display("FAIL bram_write got addr=%0d din=%0d, expected addr=%0d din=%0d",
                             bram_addr, bram_din, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic last);
        bit  ok;
        int  t;
        wr_t e;
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = last;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 64) begin
            @(negedge clk);
            ok = (sif.s_ready === 1'b1);
            @(posedge clk);
            t++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout got s_ready=0 for %0d cycles, expected 1", t);
        end else begin
            e.addr = 8'(next_addr);
            e.data = 16'(ref_mod(int'(d)));
            exp_q.push_back(e);
            exp_mem[next_addr] = e.data;
            next_addr++;
        end
        #1;
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    task automatic start_load(input logic m);
        go = 1'b1;
        mode = m;
        next_addr = 0;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        go = 1'b1;
        sif.s_valid = 1'b1;
        sif.s_data = 16'd5;
        sif.s_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({sif.s_ready, bram_we, bram_addr, bram_din, ntt_start, ntt_mode, busy, done, err_len} !== 31'd0) begin
                failures++;
                $display("FAIL reset_outputs got %b, expected all zero",
                         {sif.s_ready, bram_we, bram_addr, bram_din, ntt_start, ntt_mode, busy, done, err_len});
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        go = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_last = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || writes !== 0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b writes=%0d, expected busy=0 writes=0", busy, writes);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp;
        int w0, s0, d0, bad;
        w0 = writes; s0 = starts; d0 = dones;
        start_load(1'b1);
        for (int k = 0; k < 256; k++) send_beat(16'(k), (k == 255));
        @(negedge clk);
        checks++;
        if (ntt_start !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ramp_flush got ntt_start=%b busy=%b, expected 0 1", ntt_start, busy);
        end
        @(negedge clk);
        checks++;
        if (ntt_start !== 1'b1 || ntt_mode !== 1'b1) begin
            failures++;
            $display("FAIL ramp_start got ntt_start=%b ntt_mode=%b, expected 1 1", ntt_start, ntt_mode);
        end
        @(negedge clk);
        checks++;
        if (ntt_start !== 1'b0) begin
            failures++;
            $display("FAIL ramp_start_width got ntt_start=%b, expected 0", ntt_start);
        end
        @(posedge clk); #1; ntt_done = 1'b1;
        @(posedge clk); #1; ntt_done = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ramp_done got done=%b, expected 1", done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ramp_idle got done=%b busy=%b, expected 0 0", done, busy);
        end
        @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== 16'(k)) bad++;
        checks++;
        if (bad != 0 || writes - w0 != 256 || starts - s0 != 1 || dones - d0 != 1) begin
            failures++;
            $display("FAIL ramp_totals got bad=%0d writes=%0d starts=%0d dones=%0d, expected 0 256 1 1",
                     bad, writes - w0, starts - s0, dones - d0);
        end
    endtask

    task automatic test_reduction;
        logic [15:0] want [4];
        logic [15:0] din [4];
        want = '{16'd0, 16'd3328, 16'd2284, 16'd0};
        din  = '{16'd3329, 16'd3328, 16'd65535, 16'd6658};
        start_load(1'b0);
        for (int k = 0; k < 4; k++) send_beat(din[k], 1'b0);
        for (int k = 4; k < 256; k++) send_beat(16'($urandom_range(0, 65535)), (k == 255));
        @(posedge clk); #1; ntt_done = 1'b1;
        @(negedge clk);
        checks++;
        if (ntt_start !== 1'b1 || ntt_mode !== 1'b0) begin
            failures++;
            $display("FAIL red_start got ntt_start=%b ntt_mode=%b, expected 1 0", ntt_start, ntt_mode);
        end
        @(posedge clk); #1; ntt_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL kick_done_ignored got done=%b busy=%b, expected 0 1", done, busy);
            end
        end
        @(posedge clk); #1; ntt_done = 1'b1;
        @(posedge clk); #1; ntt_done = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL red_done got done=%b, expected 1", done);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[k] !== want[k]) begin
                failures++;
                $display("FAIL reduction[%0d] got %0d, expected %0d", k, mem[k], want[k]);
            end
        end
    endtask

    task automatic test_early_last;
        int w0, s0;
        w0 = writes; s0 = starts;
        start_load(1'b0);
        for (int k = 0; k < 11; k++) send_beat(16'($urandom_range(0, 65535)), (k == 10));
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err_len !== 1'b1) begin
            failures++;
            $display("FAIL early_state got busy=%b err_len=%b, expected 0 1", busy, err_len);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (writes - w0 != 11 || starts != s0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL early_totals got writes=%0d starts=%0d pending=%0d, expected 11 0 0",
                     writes - w0, starts - s0, exp_q.size());
        end
        go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        @(negedge clk);
        checks++;
        if (err_len !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL early_go_clear got err_len=%b busy=%b, expected 0 1", err_len, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
    endtask

    task automatic test_gaps_missing_last;
        int w0, s0, d0, t, bad;
        w0 = writes; s0 = starts; d0 = dones;
        start_load(1'b1);
        for (int k = 0; k < 256; k++) begin
            send_beat(16'($urandom_range(0, 65535)), 1'b0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        t = 0;
        while (starts == s0 && t < 20) begin
            @(posedge clk); t++;
        end
        @(negedge clk);
        checks++;
        if (starts - s0 != 1 || err_len !== 1'b1) begin
            failures++;
            $display("FAIL gaps_start got starts=%0d err_len=%b, expected 1 1", starts - s0, err_len);
        end
        @(posedge clk); #1; ntt_done = 1'b1;
        @(posedge clk); #1; ntt_done = 1'b0;
        t = 0;
        while (dones == d0 && t < 20) begin
            @(posedge clk); t++;
        end
        #1;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) bad++;
        checks++;
        if (dones - d0 != 1 || starts - s0 != 1 || writes - w0 != 256 || bad != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL gaps_totals got dones=%0d starts=%0d writes=%0d bad=%0d pending=%0d, expected 1 1 256 0 0",
                     dones - d0, starts - s0, writes - w0, bad, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_load;
        int w0, s0, d0, t, bad;
        s0 = starts;
        start_load(1'b0);
        for (int k = 0; k < 100; k++) send_beat(16'($urandom_range(0, 65535)), 1'b0);
        rst = 1'b0;
        sif.s_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        sif.s_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || starts != s0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_state got busy=%b starts=%0d pending=%0d, expected 0 0 0",
                     busy, starts - s0, exp_q.size());
        end
        @(posedge clk); #1;
        w0 = writes; s0 = starts; d0 = dones;
        start_load(1'b1);
        for (int k = 0; k < 256; k++) send_beat(16'($urandom_range(0, 65535)), (k == 255));
        t = 0;
        while (starts == s0 && t < 20) begin
            @(posedge clk); t++;
        end
        #1; ntt_done = 1'b1;
        @(posedge clk); #1; ntt_done = 1'b0;
        t = 0;
        while (dones == d0 && t < 20) begin
            @(posedge clk); t++;
        end
        #1;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) bad++;
        checks++;
        if (dones - d0 != 1 || starts - s0 != 1 || writes - w0 != 256 || bad != 0 || err_len !== 1'b0 || ntt_mode !== 1'b1) begin
            failures++;
            $display("FAIL rerun_totals got dones=%0d starts=%0d writes=%0d bad=%0d err=%b mode=%b, expected 1 1 256 0 0 1",
                     dones - d0, starts - s0, writes - w0, bad, err_len, ntt_mode);
        end
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = 16'd0;
        sif.s_last  = 1'b0;
        test_reset();
        test_ramp();
        test_reduction();
        test_early_last();
        test_gaps_missing_last();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
